// File: rtl/dsp_mac_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_pipe_if
// Brief    : Operand/result bundle of the pipelined pre-add/multiply/post-add slice.
// Revision : 1.0
// ============================================================================
interface dsp_mac_pipe_if #(
   parameter int A_W = 18,
   parameter int B_W = 18,
   parameter int P_W = 48
);
   logic                 in_valid;
   logic [A_W-1:0]       A;
   logic [B_W-1:0]       B;
   logic [B_W-1:0]       BCIN;
   logic [B_W-1:0]       D;
   logic [P_W-1:0]       C;
   logic [P_W-1:0]       PCIN;
   logic                 carryin;
   logic [7:0]           opmode;
   logic [A_W+B_W-1:0]   M;
   logic [P_W-1:0]       P;
   logic [P_W-1:0]       PCOUT;
   logic [B_W-1:0]       BCOUT;
   logic                 carryout;
   logic                 carryoutF;
   logic                 out_valid;
   logic                 ovf;

   modport master (
      output in_valid, A, B, BCIN, D, C, PCIN, carryin, opmode,
      input  M, P, PCOUT, BCOUT, carryout, carryoutF, out_valid, ovf
   );

   modport slave (
      input  in_valid, A, B, BCIN, D, C, PCIN, carryin, opmode,
      output M, P, PCOUT, BCOUT, carryout, carryoutF, out_valid, ovf
   );
endinterface
`default_nettype wire

// File: rtl/dsp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_pipe
// Brief    : Pre-adder -> multiplier -> post-adder/accumulator, fixed latency
//            IREG+MREG+PREG. Optional macro DSP_SAT_EN: unsigned saturation.
// Revision : 1.0
// ============================================================================
module dsp_mac_pipe #(
   parameter int    A_W        = 18,
   parameter int    B_W        = 18,
   parameter int    P_W        = 48,
   parameter int    IREG       = 1,
   parameter int    MREG       = 1,
   parameter int    PREG       = 1,
   parameter string B_INPUT    = "DIRECT",
   parameter string CARRYINSEL = "CARRYIN"
) (
   input  wire logic     clk,
   input  wire logic     RST,
   input  wire logic     CE,
   dsp_mac_pipe_if.slave bus
);
   localparam int M_W   = A_W + B_W;
   localparam int DAB_W = A_W + 2*B_W;

   // op keeps {post-sub, pre-sub, use-pre, Z[1:0], X[1:0]}; opmode[5] is folded into cin
   typedef struct packed {
      logic           vld;
      logic           cin;
      logic [6:0]     op;
      logic [P_W-1:0] pcin;
      logic [P_W-1:0] c;
      logic [B_W-1:0] d;
      logic [B_W-1:0] bsel;
      logic [A_W-1:0] a;
   } in_t;

   typedef struct packed {
      logic             vld;
      logic             cin;
      logic [4:0]       op;
      logic [P_W-1:0]   pcin;
      logic [P_W-1:0]   c;
      logic [DAB_W-1:0] dab;
      logic [M_W-1:0]   m;
   } mul_t;

   typedef struct packed {
      logic           vld;
      logic           ovf;
      logic           co;
      logic [P_W-1:0] p;
   } out_t;

   in_t            in_d, in_s;
   mul_t           mul_d, mul_s;
   out_t           out_d, out_s;
   logic [B_W-1:0] pre;
   logic [P_W-1:0] p_fb;
   logic [P_W-1:0] x_sel, z_sel;
   logic [P_W:0]   x_cin, sum;

   always_comb begin
      in_d.vld  = bus.in_valid;
      in_d.cin  = (CARRYINSEL == "OPMODE5") ? bus.opmode[5] : bus.carryin;
      in_d.op   = {bus.opmode[7], bus.opmode[6], bus.opmode[4], bus.opmode[3:0]};
      in_d.pcin = bus.PCIN;
      in_d.c    = bus.C;
      in_d.d    = bus.D;
      in_d.bsel = (B_INPUT == "CASCADE") ? bus.BCIN : bus.B;
      in_d.a    = bus.A;
   end

   generate
      if (IREG != 0) begin : g_ireg
         in_t in_q;
         always_ff @(posedge clk) begin
            if (RST)     in_q <= '0;
            else if (CE) in_q <= in_d;
         end
         assign in_s = in_q;
      end else begin : g_ibyp
         assign in_s = in_d;
      end
   endgenerate

   always_comb begin
      if (!in_s.op[4])     pre = in_s.bsel;
      else if (in_s.op[5]) pre = in_s.d - in_s.bsel;
      else                 pre = in_s.d + in_s.bsel;
   end

   always_comb begin
      mul_d.vld  = in_s.vld;
      mul_d.cin  = in_s.cin;
      mul_d.op   = {in_s.op[6], in_s.op[3:0]};
      mul_d.pcin = in_s.pcin;
      mul_d.c    = in_s.c;
      mul_d.dab  = {in_s.d, in_s.a, in_s.bsel};
      mul_d.m    = M_W'(in_s.a) * M_W'(pre);
   end

   generate
      if (MREG != 0) begin : g_mreg
         mul_t mul_q;
         always_ff @(posedge clk) begin
            if (RST)     mul_q <= '0;
            else if (CE) mul_q <= mul_d;
         end
         assign mul_s = mul_q;
      end else begin : g_mbyp
         assign mul_s = mul_d;
      end
   endgenerate

   always_comb begin
      case (mul_s.op[1:0])
         2'd0:    x_sel = '0;
         2'd1:    x_sel = P_W'(mul_s.m);
         2'd2:    x_sel = p_fb;
         default: x_sel = P_W'(mul_s.dab);
      endcase
      case (mul_s.op[3:2])
         2'd0:    z_sel = '0;
         2'd1:    z_sel = mul_s.pcin;
         2'd2:    z_sel = p_fb;
         default: z_sel = mul_s.c;
      endcase
   end

   // One extra bit keeps the carry (add) or borrow (subtract) visible
   always_comb begin
      x_cin = {1'b0, x_sel} + (P_W+1)'(mul_s.cin);
      if (mul_s.op[4]) sum = {1'b0, z_sel} - x_cin;
      else             sum = {1'b0, z_sel} + x_cin;
   end

   always_comb begin
      out_d.vld = mul_s.vld;
      out_d.co  = sum[P_W];
`ifdef DSP_SAT_EN
      if (sum[P_W]) begin
         out_d.p   = mul_s.op[4] ? '0 : '1;
         out_d.ovf = 1'b1;
      end else begin
         out_d.p   = sum[P_W-1:0];
         out_d.ovf = 1'b0;
      end
`else
      out_d.p   = sum[P_W-1:0];
      out_d.ovf = 1'b0;
`endif
   end

   // Without a P register the feedback selection reads zero, so no combinational loop forms
   generate
      if (PREG != 0) begin : g_preg
         out_t out_q;
         always_ff @(posedge clk) begin
            if (RST)     out_q <= '0;
            else if (CE) out_q <= out_d;
         end
         assign out_s = out_q;
         assign p_fb  = out_q.p;
      end else begin : g_pbyp
         assign out_s = out_d;
         assign p_fb  = '0;
      end
   endgenerate

   assign bus.M         = mul_s.m;
   assign bus.BCOUT     = in_s.bsel;
   assign bus.P         = out_s.p;
   assign bus.PCOUT     = out_s.p;
   assign bus.carryout  = out_s.co;
   assign bus.carryoutF = out_s.co;
   assign bus.out_valid = out_s.vld;
   assign bus.ovf       = out_s.ovf;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_pipe
// Brief    : Directed-vector bench for dsp_mac_pipe with a latency-delayed model.
// Revision : 1.0
// ============================================================================
module tb_dsp_mac_pipe;
   localparam int A_W = 18;
   localparam int B_W = 18;
   localparam int P_W = 48;

   logic clk = 1'b0;
   logic RST = 1'b1;
   logic CE  = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   dsp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

   dsp_mac_pipe #(
      .A_W(A_W), .B_W(B_W), .P_W(P_W),
      .IREG(1), .MREG(1), .PREG(1),
      .B_INPUT("DIRECT"), .CARRYINSEL("CARRYIN")
   ) dut (
      .clk(clk),
      .RST(RST),
      .CE (CE),
      .bus(bus)
   );

   typedef struct packed {
      logic           v;
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic [B_W-1:0] d;
      logic [P_W-1:0] c;
      logic [P_W-1:0] pcin;
      logic           cin;
      logic [7:0]     op;
   } set_t;

   // Model state: inputs seen one and two enabled edges ago, plus expected outputs
   set_t               h0, h1, cur;
   logic [P_W-1:0]     pm;
   logic [A_W+B_W-1:0] mm;
   logic [B_W-1:0]     bcm;
   logic               vm, com, ovm;
   bit                 ready = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [A_W+B_W-1:0] product(input set_t s);
      logic [B_W-1:0]     pre;
      logic [A_W+B_W-1:0] ea, ep;
      if (!s.op[4])     pre = s.b;
      else if (s.op[6]) pre = s.d - s.b;
      else              pre = s.d + s.b;
      ea = {{B_W{1'b0}}, s.a};
      ep = {{A_W{1'b0}}, pre};
      return ea * ep;
   endfunction

   task automatic model_post(input set_t s);
      logic [P_W-1:0]       x, z;
      logic [P_W:0]         r;
      logic [A_W+2*B_W-1:0] dab;
      dab = {s.d, s.a, s.b};
      case (s.op[1:0])
         2'd0:    x = '0;
         2'd1:    x = {{(P_W-A_W-B_W){1'b0}}, product(s)};
         2'd2:    x = pm;
         default: x = dab[P_W-1:0];
      endcase
      case (s.op[3:2])
         2'd0:    z = '0;
         2'd1:    z = s.pcin;
         2'd2:    z = pm;
         default: z = s.c;
      endcase
      if (s.op[7]) r = {1'b0, z} - ({1'b0, x} + {{P_W{1'b0}}, s.cin});
      else         r = {1'b0, z} + {1'b0, x} + {{P_W{1'b0}}, s.cin};
      com = r[P_W];
      pm  = r[P_W-1:0];
      ovm = 1'b0;
`ifdef DSP_SAT_EN
      if (r[P_W]) begin
         pm  = s.op[7] ? '0 : '1;
         ovm = 1'b1;
      end
`endif
      vm = s.v;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cur = {bus.in_valid, bus.A, bus.B, bus.D, bus.C, bus.PCIN, bus.carryin, bus.opmode};
         if (RST) begin
            h0 = '0; h1 = '0; pm = '0; mm = '0; bcm = '0;
            vm = 1'b0; com = 1'b0; ovm = 1'b0;
            ready = 1'b1;
         end else if (CE) begin
            model_post(h1);
            mm  = product(h0);
            bcm = cur.b;
            h1  = h0;
            h0  = cur;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (ready) begin
            chk("P",         bus.P,         pm);
            chk("PCOUT",     bus.PCOUT,     pm);
            chk("carryout",  bus.carryout,  com);
            chk("carryoutF", bus.carryoutF, com);
            chk("out_valid", bus.out_valid, vm);
            chk("ovf",       bus.ovf,       ovm);
            chk("M",         bus.M,         mm);
            chk("BCOUT",     bus.BCOUT,     bcm);
         end
      end
   end

   task automatic apply(input logic v, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [B_W-1:0] d, input logic [P_W-1:0] c,
                        input logic [P_W-1:0] pcin, input logic cin, input logic [7:0] op);
      bus.in_valid = v;  bus.A = a;  bus.B = b;  bus.D = d;  bus.C = c;
      bus.PCIN = pcin;   bus.carryin = cin;  bus.opmode = op;  bus.BCIN = 18'h2AAAA;
   endtask

   task automatic idle();
      apply(1'b0, '0, '0, '0, '0, '0, 1'b0, 8'h00);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Reset with nonzero inputs on the bus
      apply(1'b1, 18'h3FFFF, 18'h12345, 18'h00777, 48'hFFFF_0000_1234, 48'h5, 1'b1, 8'hFF);
      RST = 1'b1;
      tick(2);
      chk("rst_P",      bus.P,         0);
      chk("rst_M",      bus.M,         0);
      chk("rst_PCOUT",  bus.PCOUT,     0);
      chk("rst_BCOUT",  bus.BCOUT,     0);
      chk("rst_co",     bus.carryout,  0);
      chk("rst_valid",  bus.out_valid, 0);
      RST = 1'b0;
      idle();
      tick(3);

      // Pre-subtract: (10-4)*4
      apply(1'b1, 18'd4, 18'd4, 18'd10, '0, '0, 1'b0, 8'b0101_0001);
      tick();
      idle();
      tick();
      chk("presub_M", bus.M, 24);
      tick();
      chk("presub_P",     bus.P,         24);
      chk("presub_valid", bus.out_valid, 1);
      tick(3);

      // Same operand set with a two-cycle stall after the first edge
      apply(1'b1, 18'd4, 18'd4, 18'd10, '0, '0, 1'b0, 8'b0101_0001);
      tick();
      idle();
      CE = 1'b0;
      tick(2);
      chk("stall_P",     bus.P,         0);
      chk("stall_valid", bus.out_valid, 0);
      CE = 1'b1;
      tick(2);
      chk("stall_P_out",     bus.P,         24);
      chk("stall_valid_out", bus.out_valid, 1);
      tick(3);

      // Accumulate 2*3 four times
      for (int i = 0; i < 8; i++) begin
         if (i < 4) apply(1'b1, 18'd2, 18'd3, '0, '0, '0, 1'b0, 8'b0000_1001);
         else       idle();
         tick();
         if (i >= 2 && i <= 5) begin
            chk("acc_P",     bus.P,         64'(6 * (i - 1)));
            chk("acc_valid", bus.out_valid, 1);
         end
      end
      tick(2);

      // Post-subtract: 100 - (15 + 1)
      apply(1'b1, 18'd3, 18'd5, '0, 48'd100, '0, 1'b1, 8'b1000_1101);
      tick();
      idle();
      tick(2);
      chk("postsub_P",  bus.P,        84);
      chk("postsub_co", bus.carryout, 0);
      tick(3);

      // Post-add overflow: (2^48-1) + 1
      apply(1'b1, 18'd1, 18'd1, '0, {P_W{1'b1}}, '0, 1'b0, 8'b0000_1101);
      tick();
      idle();
      tick(2);
      chk("ovf_co", bus.carryout, 1);
`ifdef DSP_SAT_EN
      chk("ovf_P",    bus.P,   64'hFFFF_FFFF_FFFF);
      chk("ovf_flag", bus.ovf, 1);
`else
      chk("ovf_P",    bus.P,   0);
      chk("ovf_flag", bus.ovf, 0);
`endif
      tick(3);

      // Reset while a valid set is in flight
      apply(1'b1, 18'd7, 18'd9, '0, '0, '0, 1'b0, 8'b0000_0001);
      tick();
      idle();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick();
      chk("flush_valid", bus.out_valid, 0);
      tick();
      chk("flush_valid2", bus.out_valid, 0);
      chk("flush_P",      bus.P,         0);
      tick(2);

      // Mixed X/Z selections, checked by the model each cycle
      apply(1'b1, 18'd2, 18'd3, 18'h3F001, '0, 48'd5, 1'b0, 8'b0000_0111);
      tick();
      apply(1'b1, '0, '0, '0, 48'd7, '0, 1'b0, 8'b0000_1110);
      tick();
      apply(1'b1, 18'd5, 18'd2, 18'd3, '0, '0, 1'b0, 8'b1001_0001);
      tick();
      apply(1'b1, '0, '0, '0, '0, '0, 1'b1, 8'b0000_1000);
      tick();
      apply(1'b1, 18'h3FFFF, 18'h3FFFF, 18'h00001, '0, '0, 1'b0, 8'b0001_0001);
      tick();
      idle();
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
